// File: rtl/kypd_pkg.sv
// Shared types and constants for the PmodKYPD scan/debounce front end.
package kypd_pkg;

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_KEYS = NUM_COLS * NUM_ROWS;

  typedef logic [3:0] key_code_t;

  // Scan snapshot classification.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    MULTI = 2'd2
  } cls_e;

  // One classified scan: class plus key code (code is 0 unless class is KEY).
  typedef struct packed {
    cls_e      cls;
    key_code_t code;
  } scan_cls_t;

  // Key map, entry (col*4 + row) at bits [4*i+3:4*i].
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,   // col3 rows 3..0
    4'hE, 4'h9, 4'h6, 4'h3,   // col2
    4'hF, 4'h8, 4'h5, 4'h2,   // col1
    4'h0, 4'h7, 4'h4, 4'h1    // col0
  };

  // Key code for a pressed-vector bit index.
  function automatic key_code_t key_lookup(input logic [3:0] idx);
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/kypd_if.sv
// Key event valid/ready channel toward the display/consumer.
interface kypd_if;
  import kypd_pkg::*;

  key_code_t key_code;
  logic      key_valid;
  logic      key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/kypd_col_scan.sv
// Column driver, row synchronizer and 16-bit snapshot assembly.
module kypd_col_scan
  import kypd_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [NUM_KEYS-1:0] pressed,
  output logic                scan_done
);

  localparam int unsigned DW_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(SCAN_CYCLES - 1);

  logic [NUM_ROWS-1:0] row_meta_q, row_meta_d;
  logic [NUM_ROWS-1:0] row_sync_q, row_sync_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  logic [NUM_KEYS-1:0] accum_q, accum_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic                scan_done_q, scan_done_d;

  // Synchronize rows, step dwell/column, capture rows on the last dwell cycle.
  always_comb begin
    row_meta_d  = row;
    row_sync_d  = row_meta_q;
    dwell_d     = dwell_q;
    col_idx_d   = col_idx_q;
    col_d       = col_q;
    accum_d     = accum_q;
    snap_d      = snap_q;
    scan_done_d = 1'b0;

    if (dwell_q == DW_LAST) begin
      dwell_d = '0;
      accum_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
      col_idx_d = col_idx_q + 2'd1;
      col_d     = ~(4'b0001 << col_idx_d);
      if (col_idx_q == 2'd3) begin
        snap_d      = {~row_sync_q, accum_q[11:0]};
        scan_done_d = 1'b1;
      end
    end else begin
      dwell_d = dwell_q + DW_W'(1);
    end
  end

  // State registers; rows reset to idle (released) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      dwell_q     <= '0;
      col_idx_q   <= 2'd0;
      col_q       <= 4'b1110;
      accum_q     <= '0;
      snap_q      <= '0;
      scan_done_q <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      dwell_q     <= dwell_d;
      col_idx_q   <= col_idx_d;
      col_q       <= col_d;
      accum_q     <= accum_d;
      snap_q      <= snap_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign col       = col_q;
  assign pressed   = snap_q;
  assign scan_done = scan_done_q;

endmodule

// File: rtl/kypd_scan_debounce.sv
// Keypad scan, debounce and one-event-per-press output register.
module kypd_scan_debounce
  import kypd_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES    = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [NUM_COLS-1:0] col,
  input  logic [NUM_ROWS-1:0] row,
  kypd_if.master              key_if,
  output logic                key_held,
  output logic                overrun
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  localparam logic [0:0] STATE_IDLE = 1'b0;
  localparam logic [0:0] STATE_HELD = 1'b1;

  logic [NUM_KEYS-1:0] pressed;
  logic                scan_done;

  kypd_col_scan #(.SCAN_CYCLES(SCAN_CYCLES)) u_col_scan (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .pressed   (pressed),
    .scan_done (scan_done)
  );

  logic [4:0]  pop_c;
  logic [3:0]  hit_c;
  scan_cls_t   cand_c;

  logic [0:0]       state_q, state_d;
  scan_cls_t        prev_q, prev_d;
  logic [CNT_W-1:0] match_q, match_d;
  key_code_t        held_code_q, held_code_d;
  key_code_t        key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             overrun_q, overrun_d;
  logic             press_c;
  logic             accept_c;

  // Classify the snapshot: count set bits and remember the set index.
  always_comb begin
    pop_c = '0;
    hit_c = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (pressed[i]) begin
        pop_c = pop_c + 5'd1;
        hit_c = 4'(i);
      end
    end
    cand_c.code = '0;
    if (pop_c == 5'd0) begin
      cand_c.cls = NONE;
    end else if (pop_c == 5'd1) begin
      cand_c.cls  = KEY;
      cand_c.code = key_lookup(hit_c);
    end else begin
      cand_c.cls = MULTI;
    end
  end

  // Debounce FSM next state and output register update.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    match_d     = match_q;
    held_code_d = held_code_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    press_c     = 1'b0;
    accept_c    = key_valid_q && key_if.key_ready;

    if (scan_done) begin
      prev_d = cand_c;
      if (cand_c.cls == MULTI) begin
        match_d = '0;
      end else begin
        if (cand_c == prev_q) begin
          match_d = (match_q == CNT_MAX) ? match_q : match_q + CNT_W'(1);
        end else begin
          match_d = CNT_W'(1);
        end
        if (match_d == CNT_MAX) begin
          case (state_q)
            STATE_IDLE: begin
              if (cand_c.cls == KEY) begin
                state_d     = STATE_HELD;
                held_code_d = cand_c.code;
                press_c     = 1'b1;
              end
            end
            default: begin
              if (cand_c.cls == NONE) begin
                state_d = STATE_IDLE;
              end else begin
                held_code_d = cand_c.code;
              end
            end
          endcase
        end
      end
    end

    if (accept_c) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (press_c) begin
      if (!key_valid_q || accept_c) begin
        key_code_d  = cand_c.code;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= STATE_IDLE;
      prev_q      <= '{cls: NONE, code: 4'h0};
      match_q     <= '0;
      held_code_q <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      held_code_q <= held_code_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key_if.key_code  = key_code_q;
  assign key_if.key_valid = key_valid_q;
  assign key_held         = (state_q == STATE_HELD);
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_kypd_scan_debounce.sv
// Scoreboard bench for kypd_scan_debounce with a behavioral keypad model.
module tb_kypd_scan_debounce;

  localparam int unsigned SC = 4;
  localparam int unsigned DS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  col;
  logic [3:0]  row;
  logic        key_held;
  logic        overrun;
  logic [15:0] keys;

  kypd_if kif ();

  always #5 clk = ~clk;

  // Keypad: a pressed key at (c,r) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (keys[c*4 + r]) row[r] = 1'b0;
  end

  kypd_scan_debounce #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DS)) dut (
    .clk      (clk),
    .rst      (rst),
    .col      (col),
    .row      (row),
    .key_if   (kif),
    .key_held (key_held),
    .overrun  (overrun)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b0 && kif.key_valid === 1'b1 && kif.key_ready === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got code %0h, expected no event", kif.key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (kif.key_code !== e) begin
          n_fail++;
          $display("FAIL event_code: got %0h, expected %0h", kif.key_code, e);
        end
      end
    end
  end

  task automatic drive_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic watch_not_held(input string name, input int n);
    logic any_held;
    any_held = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (key_held !== 1'b0) any_held = 1'b1;
    end
    check(name, 32'(any_held), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ec;
    logic       all_held;
    logic       seen;

    rst = 1'b1;
    keys = '0;
    kif.key_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_col", 32'(col), 32'hE);
    check("rst_key_valid", 32'(kif.key_valid), 32'd0);
    check("rst_key_code", 32'(kif.key_code), 32'd0);
    check("rst_key_held", 32'(key_held), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Column walk after reset release.
    drive_step();
    rst = 1'b0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      ec = 4'b0001 << ((n / 4) % 4);
      ec = ~ec;
      check($sformatf("col_walk_%0d", n), 32'(col), 32'(ec));
    end

    // Hold '5': exactly one event, key_held stays up while pressed.
    drive_step();
    keys = 16'h0001 << 5;
    exp_q.push_back(4'h5);
    wait_drain("drain_5", 200);
    all_held = 1'b1;
    repeat (48) begin
      @(negedge clk);
      if (key_held !== 1'b1) all_held = 1'b0;
    end
    check("held_5", 32'(all_held), 32'd1);
    drive_step();
    keys = '0;
    wait_cycles(64);
    check("released_5", 32'(key_held), 32'd0);

    // '9' for one scan only: no event, never held.
    drive_step();
    keys = 16'h0001 << 10;
    watch_not_held("short_9_pressed", 16);
    drive_step();
    keys = '0;
    watch_not_held("short_9_after", 64);

    // '1' and '2' together: no event; then '1' alone gives an event.
    drive_step();
    keys = (16'h0001 << 0) | (16'h0001 << 4);
    watch_not_held("multi_1_2", 64);
    drive_step();
    keys = 16'h0001 << 0;
    exp_q.push_back(4'h1);
    wait_drain("drain_1", 200);
    check("held_1", 32'(key_held), 32'd1);
    drive_step();
    keys = '0;
    wait_cycles(64);

    // Overrun: 'A' pending, 'C' dropped.
    drive_step();
    kif.key_ready = 1'b0;
    keys = 16'h0001 << 12;
    exp_q.push_back(4'hA);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("valid_A", 32'(seen), 32'd1);
    check("code_A", 32'(kif.key_code), 32'hA);
    drive_step();
    keys = '0;
    wait_cycles(64);
    drive_step();
    keys = 16'h0001 << 14;
    wait_cycles(64);
    check("held_C", 32'(key_held), 32'd1);
    drive_step();
    keys = '0;
    wait_cycles(64);
    check("ovr_code_kept", 32'(kif.key_code), 32'hA);
    check("ovr_valid_kept", 32'(kif.key_valid), 32'd1);
    check("ovr_set", 32'(overrun), 32'd1);
    drive_step();
    kif.key_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("accept_valid_drop", 32'(kif.key_valid), 32'd0);
    check("accept_ovr_clear", 32'(overrun), 32'd0);
    check("accept_drained", 32'(exp_q.size()), 32'd0);

    // Reset after one matching scan of 'D': no event, scan restarts.
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (col === 4'b0111) begin
        seen = 1'b1;
        break;
      end
    end
    for (int i = 0; i < 64 && seen; i++) begin
      @(negedge clk);
      if (col === 4'b1110) break;
    end
    check("align_col3", 32'(seen), 32'd1);
    keys = 16'h0001 << 15;
    wait_cycles(20);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_rst_col", 32'(col), 32'hE);
    check("mid_rst_valid", 32'(kif.key_valid), 32'd0);
    check("mid_rst_held", 32'(key_held), 32'd0);
    keys = '0;
    drive_step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_col", 32'(col), 32'hE);
    watch_not_held("post_rst_idle", 64);
    check("final_overrun", 32'(overrun), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
